// File: rtl/m68k_bus_decoder.sv
// m68k_bus_decoder: registered 68000 region decoder with wait states, external ready and bus-error watchdog
module m68k_bus_decoder #(
    parameter int NUM_REGIONS = 16,
    parameter int ADDR_W = 24,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = '0,
    parameter logic [NUM_REGIONS-1:0] REGION_EXT = '0,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      m68k_a,
    input  logic                   m68k_as_n,
    input  logic                   m68k_rw,
    input  logic [NUM_REGIONS-1:0] ext_ready,
    output logic [NUM_REGIONS-1:0] cs,
    output logic                   cycle_rw,
    output logic [4:0]             hit_index,
    output logic                   dtack_n,
    output logic                   berr_n,
    output logic                   busy
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_EXT = 3'd2, S_ACK = 3'd3, S_BERR = 3'd4;
    localparam logic [127:0] WAITS = 128'(REGION_WAIT);
    localparam logic [31:0] EXT_EN = 32'(REGION_EXT);

    if (TIMEOUT < 17 || NUM_REGIONS < 1 || NUM_REGIONS > 32) begin : g_bad_params
        $error("m68k_bus_decoder: TIMEOUT must be >= 17 and NUM_REGIONS 1..32");
    end

    logic [2:0]             state;
    logic [3:0]             wcnt;
    logic [TW-1:0]          tcnt;
    logic                   nohit;
    logic                   hit;
    logic [4:0]             idx;
    logic [NUM_REGIONS-1:0] onehot;
    logic [31:0]            rdy;
    logic                   ack;

    // priority decode: scanning downwards leaves the lowest matching region in idx
    always_comb begin
        hit = 1'b0;
        idx = '0;
        onehot = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (REGION_MASK[i*ADDR_W +: ADDR_W] != '0 &&
                (m68k_a & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = 5'(i);
                onehot = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign rdy = 32'(ext_ready);
    assign ack = !nohit && (state == S_WAIT ? (wcnt == 4'd0 && !EXT_EN[hit_index])
                                            : (state == S_EXT && rdy[hit_index]));

    // bus-cycle FSM; as_n released always wins, and an ack beats a coincident timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cs <= '0;
            hit_index <= '0;
            cycle_rw <= 1'b1;
            dtack_n <= 1'b1;
            berr_n <= 1'b1;
            busy <= 1'b0;
            wcnt <= '0;
            tcnt <= '0;
            nohit <= 1'b0;
        end else if (state != S_IDLE && m68k_as_n) begin
            state <= S_IDLE;
            cs <= '0;
            dtack_n <= 1'b1;
            berr_n <= 1'b1;
            busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (!m68k_as_n) begin
                    state <= S_WAIT;
                    busy <= 1'b1;
                    cycle_rw <= m68k_rw;
                    tcnt <= '0;
                    nohit <= !hit;
                    cs <= hit ? onehot : '0;
                    if (hit) begin
                        hit_index <= idx;
                        wcnt <= WAITS[{idx, 2'b00} +: 4];
                    end
                end
                S_WAIT, S_EXT: begin
                    tcnt <= tcnt + TW'(1);
                    if (ack) begin
                        state <= S_ACK;
                        dtack_n <= 1'b0;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state <= S_BERR;
                        berr_n <= 1'b0;
                        cs <= '0;
                    end else if (state == S_WAIT && !nohit) begin
                        if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
                        else state <= S_EXT;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_m68k_bus_decoder.sv
// tb_m68k_bus_decoder: scoreboard bench; stimulus queues expected responses, a monitor checks them
module tb_m68k_bus_decoder;
    localparam int K_ACK = 0, K_BERR = 1, K_ABORT = 2;
    localparam logic [16*24-1:0] BASE = {{(12*24){1'b0}}, 24'h000000, 24'h0B0000, 24'h070000, 24'h000000};
    localparam logic [16*24-1:0] MASK = {{(12*24){1'b0}}, 24'hF00000, 24'hFFC000, 24'hFFC000, 24'hFC0000};
    localparam logic [63:0] WAITV = {48'h0, 4'h1, 4'h0, 4'h2, 4'h0};

    typedef struct {
        logic [15:0] cs;
        logic [4:0]  idx;
        logic        chk_idx;
        logic        rw;
        int          lat;
        int          kind;
    } exp_t;

    logic        clk = 0;
    logic        reset_n = 0;
    logic [23:0] m68k_a = '0;
    logic        m68k_as_n = 1;
    logic        m68k_rw = 1;
    logic [15:0] ext_ready = '0;
    logic [15:0] cs;
    logic        cycle_rw;
    logic [4:0]  hit_index;
    logic        dtack_n;
    logic        berr_n;
    logic        busy;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    m68k_bus_decoder #(
        .NUM_REGIONS(16), .ADDR_W(24), .REGION_BASE(BASE), .REGION_MASK(MASK),
        .REGION_WAIT(WAITV), .REGION_EXT(16'h0004), .TIMEOUT(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .m68k_a(m68k_a), .m68k_as_n(m68k_as_n),
        .m68k_rw(m68k_rw), .ext_ready(ext_ready), .cs(cs), .cycle_rw(cycle_rw),
        .hit_index(hit_index), .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] c, input logic [4:0] i, input logic ci,
                        input logic r, input int l, input int k);
        exp_t e;
        e.cs = c; e.idx = i; e.chk_idx = ci; e.rw = r; e.lat = l; e.kind = k;
        q.push_back(e);
    endtask

    task automatic start(input logic [23:0] a, input logic r);
        @(posedge clk); #1;
        m68k_a = a;
        m68k_rw = r;
        m68k_as_n = 0;
    endtask

    task automatic stop_after(input int n);
        repeat (n) @(posedge clk);
        #1 m68k_as_n = 1;
        repeat (2) @(posedge clk);
    endtask

    // monitor: decode, response and end of cycle are the observable events
    logic busy_q = 0;
    logic responded = 0;
    int   cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_q) begin
            cnt = 0;
            responded = 0;
            if (q.size() == 0) chk("unexpected_decode", 1, 0);
            else begin
                chk("cs_at_decode", cs, q[0].cs);
                chk("busy_cycle_rw", cycle_rw, q[0].rw);
                if (q[0].chk_idx) chk("hit_index", hit_index, q[0].idx);
            end
        end else if (busy) cnt++;
        if (busy && !responded && (!dtack_n || !berr_n)) begin
            responded = 1;
            if (q.size() == 0) chk("unexpected_response", 1, 0);
            else begin
                e = q.pop_front();
                chk("response_kind", dtack_n ? K_BERR : K_ACK, e.kind);
                chk("response_latency", cnt, e.lat);
                chk("cs_at_response", cs, e.kind == K_ACK ? e.cs : 16'h0);
                chk("single_strobe", int'(dtack_n) + int'(berr_n), 1);
            end
        end
        if (!busy && busy_q) begin
            if (!responded) begin
                if (q.size() == 0) chk("unexpected_end", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("abort_kind", K_ABORT, e.kind);
                end
            end
            chk("cs_released", cs, 0);
            chk("strobes_released", {dtack_n, berr_n}, 2'b11);
        end
        busy_q = busy;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", cs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dtack", dtack_n, 1);
        chk("rst_berr", berr_n, 1);
        chk("rst_hit_index", hit_index, 0);
        chk("rst_cycle_rw", cycle_rw, 1);
        reset_n = 1;
        repeat (2) @(posedge clk);

        // R0 read, zero wait
        push(16'h0001, 5'd0, 1, 1, 1, K_ACK);
        start(24'h001234, 1);
        stop_after(4);
        // R1 write, two waits
        push(16'h0002, 5'd1, 1, 0, 3, K_ACK);
        start(24'h070010, 0);
        stop_after(6);
        // 0x050000 falls outside R0 and lands in R3
        push(16'h0008, 5'd3, 1, 1, 2, K_ACK);
        start(24'h050000, 1);
        stop_after(5);
        // R2 external ready after 5 edges; ext_ready[1] pulse must be ignored
        push(16'h0004, 5'd2, 1, 1, 6, K_ACK);
        start(24'h0B0100, 1);
        repeat (3) @(posedge clk);
        #1 ext_ready[1] = 1;
        @(posedge clk);
        #1 ext_ready[1] = 0;
        repeat (2) @(posedge clk);
        #1 ext_ready[2] = 1;
        stop_after(3);
        ext_ready = '0;
        // unmapped address -> watchdog bus error
        push(16'h0000, 5'd0, 0, 1, 32, K_BERR);
        start(24'h200000, 1);
        stop_after(35);
        // R2 with ready never raised -> bus error
        push(16'h0004, 5'd2, 1, 1, 32, K_BERR);
        start(24'h0B0000, 1);
        stop_after(35);
        // R1 aborted after one wait edge
        push(16'h0002, 5'd1, 1, 1, 0, K_ABORT);
        start(24'h070000, 1);
        repeat (2) @(posedge clk);
        #1 m68k_as_n = 1;
        repeat (2) @(posedge clk);
        // asynchronous reset during an R2 wait
        push(16'h0004, 5'd2, 1, 0, 0, K_ABORT);
        start(24'h0B0000, 0);
        repeat (4) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async_rst_cs", cs, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_strobes", {dtack_n, berr_n}, 2'b11);
        chk("async_rst_hit_index", hit_index, 0);
        chk("async_rst_cycle_rw", cycle_rw, 1);
        m68k_as_n = 1;
        @(posedge clk);
        #1 reset_n = 1;
        repeat (2) @(posedge clk);
        // ready sampled on the same edge as the timeout: ack wins
        push(16'h0004, 5'd2, 1, 1, 32, K_ACK);
        start(24'h0B0100, 1);
        repeat (32) @(posedge clk);
        #1 ext_ready[2] = 1;
        stop_after(3);
        ext_ready = '0;

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
